blinkt_frame_gen: RTL and testbench
===================================

BLINKT_FRAME_GEN -- requirements
Module: blinkt_frame_gen

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 8, the number of APA102 pixels in the chain (1..64).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 24'd1_000_000, the auto-refresh period in i_clk cycles (used only under BLINKT_AUTO_REFRESH_EN).
REQ-003 i_clk  in  1  sole clock, all logic on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_wr_en  in  1  pixel register write strobe, one cycle per write.
REQ-006 i_wr_addr  in  6  pixel index.
REQ-007 i_wr_data  in  32  pixel value: [28:24] brightness, [23:16] R, [15:8] G, [7:0] B; [31:29] ignored.
REQ-008 i_refresh  in  1  single-cycle request to transmit one full frame.
REQ-009 m_axis_data  out  32  word for the downstream LED serializer.
REQ-010 m_axis_tvalid  out  1  m_axis_data valid.
REQ-011 m_axis_tready  in  1  serializer accepts word.
REQ-012 o_busy  out  1  high from frame start until the end word is accepted.

Function
REQ-013 Writes with i_wr_addr < NUM_LEDS SHALL update the live pixel register on the next edge; writes with i_wr_addr >= NUM_LEDS SHALL be ignored.
REQ-014 FSM states SHALL be IDLE, START, PIXEL, END.
REQ-015 IDLE -> START on i_refresh (or pending request); on that edge all live pixel registers SHALL be copied to a shadow bank, o_busy set, pixel index cleared.
REQ-016 START SHALL present 32'h0000_0000; PIXEL SHALL present {3'b111, bri[4:0], B, G, R} from shadow[index], index 0 first; END SHALL present 32'hFFFF_FFFF.
REQ-017 A word transfers only on m_axis_tvalid && m_axis_tready; transitions START->PIXEL, PIXEL->PIXEL (index+1), PIXEL->END (index == NUM_LEDS-1), END->IDLE occur only on a transfer.
REQ-018 m_axis_tvalid SHALL be high in START, PIXEL and END, low in IDLE; m_axis_data SHALL remain stable while tvalid is high and tready is low.
REQ-019 First word SHALL be valid the cycle after the i_refresh edge (latency 1); with tready held high a frame SHALL take exactly NUM_LEDS+2 transfer cycles.
REQ-020 Writes during a frame SHALL update live registers only; the transmitted frame SHALL reflect shadow values (no tearing).
REQ-021 i_refresh while busy SHALL set a one-deep pending flag; further requests while pending SHALL merge; pending SHALL start a new frame from IDLE the cycle after END completes and clear.
REQ-022 A write and a refresh in the same cycle SHALL both take effect, with the write NOT included in the shadow copy.
REQ-023 o_busy SHALL fall in the cycle following the END transfer unless a pending frame starts.

Reset
REQ-024 On i_reset all live and shadow pixels SHALL be 0, state IDLE, index 0, pending 0, m_axis_tvalid 0, m_axis_data 0, o_busy 0, refresh counter 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately; no further words SHALL be presented until a new refresh.

Configuration
REQ-026 With BLINKT_AUTO_REFRESH_EN defined, a counter SHALL raise an internal refresh request every REFRESH_DIV cycles, ORed with i_refresh (pended if busy).
REQ-027 Without BLINKT_AUTO_REFRESH_EN, the counter SHALL not exist and frames SHALL start only from i_refresh.

Structure
REQ-028 Package blinkt_pkg SHALL hold the FSM state enum, START_WORD, END_WORD, HDR_BITS (3'b111) and the pixel field offsets.
REQ-029 Sub-module blinkt_pixel_regs SHALL hold live and shadow banks with write port, snapshot strobe and indexed read.

Verification
REQ-030 Write addr0=32'h1F_FF_00_00, refresh, tready=1 -> words 0x00000000, 0xFF0000FF, then 7x 0xE0000000, then 0xFFFFFFFF; o_busy low after.
REQ-031 tready toggling every other cycle -> identical word sequence, data stable during stalls, no duplicates or drops.
REQ-032 Write addr3=0x05_11_22_33 during PIXEL index 1 -> current frame sends old addr3; next frame sends 0xE5332211.
REQ-033 Three i_refresh pulses during a frame -> exactly one extra frame follows back-to-back.
REQ-034 Reset asserted at PIXEL index 4 -> tvalid 0 next cycle, all outputs at reset values; write addr 8 -> ignored.
REQ-035 BLINKT_AUTO_REFRESH_EN, REFRESH_DIV=100 -> frame start every 100 cycles with no i_refresh.

Source files
------------

// File: rtl/blinkt_pkg.sv
// -----------------------------------------------------------------------------
// blinkt_pkg
// Shared definitions for the APA102 frame generator: FSM state encoding,
// the fixed start/end frame words, the per-pixel header bits and the field
// offsets of a stored pixel value ([28:24] brightness, [23:16] R, [15:8] G,
// [7:0] B).
// -----------------------------------------------------------------------------
package blinkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_PIXEL = 2'd2,
        ST_END   = 2'd3
    } state_e;

    localparam logic [31:0] START_WORD = 32'h0000_0000;
    localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
    localparam logic [2:0]  HDR_BITS   = 3'b111;

    // Stored pixel width: bits [31:29] of a written value carry nothing.
    localparam int PIXEL_W = 29;
    localparam int BRI_LSB = 24;
    localparam int BRI_W   = 5;
    localparam int R_LSB   = 16;
    localparam int G_LSB   = 8;
    localparam int B_LSB   = 0;

    // APA102 LED frame: header + brightness, then colour bytes in B, G, R order.
    function automatic logic [31:0] pixel_word(input logic [PIXEL_W-1:0] px);
        return {HDR_BITS, px[BRI_LSB +: BRI_W], px[B_LSB +: 8], px[G_LSB +: 8], px[R_LSB +: 8]};
    endfunction

endpackage

// File: rtl/blinkt_pixel_regs.sv
// -----------------------------------------------------------------------------
// blinkt_pixel_regs
// Live and shadow pixel banks. The live bank takes host writes; the shadow
// bank is loaded from the live bank in one cycle on i_snap and is the only
// bank the transmitter reads, so a frame in flight never sees later writes.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset (clears both banks)
//   i_wr_en          live bank write strobe
//   i_wr_addr        pixel index; indices >= NUM_LEDS match nothing (ignored)
//   i_wr_data        pixel value (brightness/R/G/B fields)
//   i_snap           copy the whole live bank into the shadow bank
//   i_rd_addr        shadow read index
//   o_rd_data        shadow[i_rd_addr] (zero when out of range)
// -----------------------------------------------------------------------------
module blinkt_pixel_regs
    import blinkt_pkg::*;
#(
    parameter int NUM_LEDS = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr_en,
    input  logic [5:0]         i_wr_addr,
    input  logic [PIXEL_W-1:0] i_wr_data,
    input  logic               i_snap,
    input  logic [5:0]         i_rd_addr,
    output logic [PIXEL_W-1:0] o_rd_data
);

    logic [PIXEL_W-1:0] live_q   [NUM_LEDS];
    logic [PIXEL_W-1:0] shadow_q [NUM_LEDS];

    // The snapshot reads live_q before this edge's write lands, so a write in
    // the same cycle as a snapshot reaches the live bank only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (i_wr_en && (i_wr_addr == 6'(i))) begin
                    live_q[i] <= i_wr_data;
                end
                if (i_snap) begin
                    shadow_q[i] <= live_q[i];
                end
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (i_rd_addr == 6'(i)) begin
                o_rd_data = shadow_q[i];
            end
        end
    end

endmodule

// File: rtl/blinkt_frame_gen.sv
// -----------------------------------------------------------------------------
// blinkt_frame_gen
// Builds one APA102 frame (start word, NUM_LEDS pixel words, end word) per
// refresh request and streams it to a downstream serializer.
//
// Optional feature: define BLINKT_AUTO_REFRESH_EN to add a free-running
// counter that raises a refresh request every REFRESH_DIV cycles, ORed with
// i_refresh.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_wr_en/_addr/_data     pixel register write port
//   i_refresh               single-cycle frame request
//   m_axis_data/_tvalid     output word stream, m_axis_tready back-pressure
//   o_busy                  high from frame start until the end word is taken
//   o_dbg_state             current FSM state (blinkt_pkg::state_e encoding)
//
// Handshake: a word moves on a rising edge where m_axis_tvalid && m_axis_tready.
// Once tvalid is high, m_axis_data and tvalid hold until that transfer; tvalid
// never depends combinationally on tready.
// -----------------------------------------------------------------------------
module blinkt_frame_gen
    import blinkt_pkg::*;
#(
    parameter int          NUM_LEDS    = 8,
    parameter logic [23:0] REFRESH_DIV = 24'd1_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_en,
    input  logic [5:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic        i_refresh,
    output logic [31:0] m_axis_data,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        o_busy,
    output logic [1:0]  o_dbg_state
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_LEDS - 1);

    state_e               state_q;
    logic [5:0]           idx_q;
    logic                 pending_q;
    logic                 refresh_req;
    logic                 start_frame;
    logic                 xfer;
    logic [5:0]           next_idx;
    logic [PIXEL_W-1:0]   rd_data;
    logic                 unused_wr_hdr;

    assign unused_wr_hdr = ^i_wr_data[31:29];

`ifdef BLINKT_AUTO_REFRESH_EN
    logic [23:0] refresh_cnt_q;
    logic        auto_tick;

    assign auto_tick = (refresh_cnt_q == REFRESH_DIV - 24'd1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            refresh_cnt_q <= '0;
        end else if (auto_tick) begin
            refresh_cnt_q <= '0;
        end else begin
            refresh_cnt_q <= refresh_cnt_q + 24'd1;
        end
    end

    assign refresh_req = i_refresh | auto_tick;
`else
    logic unused_refresh_div;
    assign unused_refresh_div = ^REFRESH_DIV;
    assign refresh_req        = i_refresh;
`endif

    assign start_frame = (state_q == ST_IDLE) && (refresh_req || pending_q);
    assign xfer        = m_axis_tvalid && m_axis_tready;

    // Index of the pixel word to load on the next transfer: pixel 0 when
    // leaving START, otherwise the one after the word now on the bus.
    assign next_idx = (state_q == ST_START) ? 6'd0 : idx_q + 6'd1;

    blinkt_pixel_regs #(
        .NUM_LEDS (NUM_LEDS)
    ) u_pixel_regs (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data[PIXEL_W-1:0]),
        .i_snap    (start_frame),
        .i_rd_addr (next_idx),
        .o_rd_data (rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_data   <= '0;
            o_busy        <= 1'b0;
        end else begin
            // Requests arriving mid-frame collapse into one pending frame.
            if ((state_q != ST_IDLE) && refresh_req) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_frame) begin
                        state_q       <= ST_START;
                        idx_q         <= '0;
                        pending_q     <= 1'b0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_data   <= START_WORD;
                        o_busy        <= 1'b1;
                    end
                end
                ST_START: begin
                    if (xfer) begin
                        state_q     <= ST_PIXEL;
                        idx_q       <= '0;
                        m_axis_data <= pixel_word(rd_data);
                    end
                end
                ST_PIXEL: begin
                    if (xfer) begin
                        if (idx_q == LAST_IDX) begin
                            state_q     <= ST_END;
                            m_axis_data <= END_WORD;
                        end else begin
                            idx_q       <= next_idx;
                            m_axis_data <= pixel_word(rd_data);
                        end
                    end
                end
                ST_END: begin
                    if (xfer) begin
                        state_q       <= ST_IDLE;
                        m_axis_tvalid <= 1'b0;
                        m_axis_data   <= '0;
                        // Stay busy across the idle cycle if another frame is queued.
                        o_busy        <= pending_q | refresh_req;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_blinkt_frame_gen.sv
module tb_blinkt_frame_gen;

  logic        i_clk;
  logic        i_reset;
  logic        i_wr_en;
  logic [5:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        i_refresh;
  logic [31:0] m_axis_data;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        o_busy;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] px [8];
  int cyc;

  blinkt_frame_gen #(
    .NUM_LEDS    (8),
    .REFRESH_DIV (24'd100)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_wr_en       (i_wr_en),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data),
    .i_refresh     (i_refresh),
    .m_axis_data   (m_axis_data),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .o_busy        (o_busy),
    .o_dbg_state   (o_dbg_state)
  );

  // clock / reset block
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic write_px(input logic [5:0] addr, input logic [31:0] data);
    i_wr_en   = 1'b1;
    i_wr_addr = addr;
    i_wr_data = data;
    step();
    i_wr_en   = 1'b0;
  endtask

  task automatic pulse_refresh(input bit with_wr, input logic [5:0] addr, input logic [31:0] data);
    i_refresh = 1'b1;
    i_wr_en   = with_wr;
    i_wr_addr = addr;
    i_wr_data = data;
    step();
    i_refresh = 1'b0;
    i_wr_en   = 1'b0;
  endtask

  // Expected frame: start word, the eight hand-computed pixel words, end word.
  task automatic push_frame();
    exp_q.push_back(32'h0000_0000);
    for (int i = 0; i < 8; i++) exp_q.push_back(px[i]);
    exp_q.push_back(32'hFFFF_FFFF);
  endtask

  // Consumes exp_q as words transfer. Optional one-shot write when wr_at
  // words have been accepted, and refresh pulses at accepted-word counts set
  // in ref_mask. With toggle set, tready alternates low/high each cycle.
  task automatic run_frame(input string tag, input bit toggle, input int wr_at,
                           input logic [5:0] wa, input logic [31:0] wd,
                           input logic [15:0] ref_mask, output int cycles);
    int          cnt;
    bit          stall;
    bit          wr_done;
    logic [15:0] ref_done;
    logic [31:0] held;
    logic [31:0] exp_w;
    cnt      = 0;
    stall    = 1'b0;
    wr_done  = 1'b0;
    ref_done = '0;
    held     = '0;
    cycles   = 0;
    while (exp_q.size() > 0 && cycles < 200) begin
      i_wr_en   = 1'b0;
      i_refresh = 1'b0;
      if (cnt == wr_at && !wr_done) begin
        i_wr_en   = 1'b1;
        i_wr_addr = wa;
        i_wr_data = wd;
        wr_done   = 1'b1;
      end
      if (cnt < 16 && ref_mask[cnt] && !ref_done[cnt]) begin
        i_refresh     = 1'b1;
        ref_done[cnt] = 1'b1;
      end
      m_axis_tready = toggle ? 1'(cycles % 2) : 1'b1;
      if (stall) begin
        check({tag, " stall_tvalid"}, 32'(m_axis_tvalid), 32'd1);
        check({tag, " stall_data"}, m_axis_data, held);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        exp_w = exp_q.pop_front();
        check($sformatf("%s word%0d", tag, cnt), m_axis_data, exp_w);
        cnt++;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      held  = m_axis_data;
      step();
      cycles++;
    end
    i_wr_en       = 1'b0;
    i_refresh     = 1'b0;
    m_axis_tready = 1'b1;
    check({tag, " words_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    i_reset       = 1'b1;
    i_wr_en       = 1'b0;
    i_wr_addr     = '0;
    i_wr_data     = '0;
    i_refresh     = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) step();
    i_reset = 1'b0;

    // reset state
    check("rst tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst data", m_axis_data, 32'h0);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst state", 32'(o_dbg_state), 32'd0);

    // basic frame, tready held high
    write_px(6'd0, 32'h1FFF_0000);
    pulse_refresh(1'b0, 6'd0, 32'h0);
    check("lat tvalid", 32'(m_axis_tvalid), 32'd1);
    check("lat data", m_axis_data, 32'h0000_0000);
    check("lat busy", 32'(o_busy), 32'd1);
    check("lat state", 32'(o_dbg_state), 32'd1);
    px = '{32'hFF00_00FF, 32'hE000_0000, 32'hE000_0000, 32'hE000_0000,
           32'hE000_0000, 32'hE000_0000, 32'hE000_0000, 32'hE000_0000};
    push_frame();
    run_frame("basic", 1'b0, -1, 6'd0, 32'h0, 16'h0, cyc);
    check("basic cycles", 32'(cyc), 32'd10);
    check("basic busy_after", 32'(o_busy), 32'd0);
    check("basic tvalid_after", 32'(m_axis_tvalid), 32'd0);

    // same frame with back-pressure every other cycle
    pulse_refresh(1'b0, 6'd0, 32'h0);
    push_frame();
    run_frame("toggle", 1'b1, -1, 6'd0, 32'h0, 16'h0, cyc);
    check("toggle busy_after", 32'(o_busy), 32'd0);

    // write to addr3 while pixel 1 is on the bus: old value goes out
    write_px(6'd3, 32'h0AAB_CDEF);
    pulse_refresh(1'b0, 6'd0, 32'h0);
    px[3] = 32'hEAEF_CDAB;
    push_frame();
    run_frame("tear", 1'b0, 2, 6'd3, 32'h0511_2233, 16'h0, cyc);

    // next frame shows the new addr3; write to addr1 in the refresh cycle is not captured
    pulse_refresh(1'b1, 6'd1, 32'h0301_0203);
    px[3] = 32'hE533_2211;
    push_frame();
    run_frame("newval", 1'b0, -1, 6'd0, 32'h0, 16'h0, cyc);

    // three refreshes during a frame queue exactly one extra frame
    pulse_refresh(1'b0, 6'd0, 32'h0);
    px[1] = 32'hE303_0201;
    push_frame();
    run_frame("pend1", 1'b0, -1, 6'd0, 32'h0, 16'h0054, cyc);
    check("pend gap busy", 32'(o_busy), 32'd1);
    check("pend gap tvalid", 32'(m_axis_tvalid), 32'd0);
    step();
    check("pend2 tvalid", 32'(m_axis_tvalid), 32'd1);
    check("pend2 state", 32'(o_dbg_state), 32'd1);
    push_frame();
    run_frame("pend2", 1'b0, -1, 6'd0, 32'h0, 16'h0, cyc);
    check("pend2 busy_after", 32'(o_busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("no third frame", 32'(m_axis_tvalid), 32'd0);
      step();
    end

    // out-of-range writes leave the frame unchanged
    write_px(6'd8, 32'hFFFF_FFFF);
    write_px(6'd63, 32'hFFFF_FFFF);
    pulse_refresh(1'b0, 6'd0, 32'h0);
    push_frame();
    run_frame("oob", 1'b0, -1, 6'd0, 32'h0, 16'h0, cyc);

    // reset while pixel 4 is presented
    pulse_refresh(1'b0, 6'd0, 32'h0);
    repeat (5) step();
    check("midrst pre state", 32'(o_dbg_state), 32'd2);
    check("midrst pre data", m_axis_data, 32'hE000_0000);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("midrst tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midrst data", m_axis_data, 32'h0);
    check("midrst busy", 32'(o_busy), 32'd0);
    check("midrst state", 32'(o_dbg_state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst quiet", 32'(m_axis_tvalid), 32'd0);
    end

    // after reset every pixel is cleared; addr 8 write ignored
    write_px(6'd8, 32'h1F12_3456);
    pulse_refresh(1'b0, 6'd0, 32'h0);
    for (int i = 0; i < 8; i++) px[i] = 32'hE000_0000;
    push_frame();
    run_frame("postrst", 1'b0, -1, 6'd0, 32'h0, 16'h0, cyc);
    check("postrst cycles", 32'(cyc), 32'd10);
    check("postrst busy_after", 32'(o_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
